serial_not_inverter: RTL and testbench

Bit-serial word inverter: produces the bitwise complement of a WIDTH-bit word using only NOT_GATES single-bit inverters in the datapath, time-shared over WIDTH/NOT_GATES cycles. It is the sequential, parametrised generalisation of the team's fixed 3-bit, 2-inverter combinational puzzle. Inverter count is traded for latency, and words move through valid/ready handshakes on both sides.

---
 rtl/serial_not_inverter.sv | 110 +++++++++++
 tb/tb_serial_not_inverter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_not_inverter.sv
// Bit-serial word inverter: complements a WIDTH-bit word with NOT_GATES one-bit
// inverters, time-shared over WIDTH/NOT_GATES beats, with valid/ready on both sides.
module serial_not_inverter #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned NOT_GATES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned BEATS = (NOT_GATES == 0) ? 1 : WIDTH / NOT_GATES;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("serial_not_inverter: WIDTH must be in 1..32");
    end
    if (NOT_GATES < 1 || NOT_GATES > WIDTH || (WIDTH % NOT_GATES) != 0) begin : g_bad_gates
        $error("serial_not_inverter: NOT_GATES must divide WIDTH and lie in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] src_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] beat_cnt;

    logic [NOT_GATES-1:0] inv_bits;
    logic [WIDTH-1:0]     src_next;
    logic [WIDTH-1:0]     res_next;

    // The only data inverters: one per gate, fed from the low end of src_sr.
    for (genvar g = 0; g < NOT_GATES; g++) begin : g_not
        assign inv_bits[g] = ~src_sr[g];
    end

    if (BEATS == 1) begin : g_single_beat
        assign src_next = '0;
        assign res_next = inv_bits;
    end else begin : g_multi_beat
        assign src_next = {{NOT_GATES{1'b0}}, src_sr[WIDTH-1:NOT_GATES]};
        assign res_next = {inv_bits, res_sr[WIDTH-1:NOT_GATES]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            src_sr    <= '0;
            res_sr    <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        src_sr   <= in_data;
                        beat_cnt <= '0;
                        state    <= StShift;
                        busy     <= 1'b1;
                    end
                end
                StShift: begin
                    src_sr   <= src_next;
                    res_sr   <= res_next;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    // res_sr is left untouched here so out_data holds under backpressure.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            src_sr   <= in_data;
                            beat_cnt <= '0;
                            state    <= StShift;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ~reset & ((state == StIdle) | ((state == StDone) & out_ready));
    assign out_data = res_sr;

endmodule

// File: tb/tb_serial_not_inverter.sv
// Directed bench for serial_not_inverter across four parameter sets sharing clk and reset.
module tb_serial_not_inverter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;
    int lat;

    // a: WIDTH=3 NOT_GATES=1, b: 8/2, c: 3/3, d: 8/1
    logic       a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic       a_in_ready, a_out_valid, a_busy;
    logic [2:0] a_in_data = '0, a_out_data;
    logic       b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic       b_in_ready, b_out_valid, b_busy;
    logic [7:0] b_in_data = '0, b_out_data;
    logic       c_in_valid = 1'b0, c_out_ready = 1'b1;
    logic       c_in_ready, c_out_valid, c_busy;
    logic [2:0] c_in_data = '0, c_out_data;
    logic       d_in_valid = 1'b0, d_out_ready = 1'b1;
    logic       d_in_ready, d_out_valid, d_busy;
    logic [7:0] d_in_data = '0, d_out_data;

    logic [2:0] exp_a [8];

    serial_not_inverter #(.WIDTH(3), .NOT_GATES(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .busy(a_busy)
    );
    serial_not_inverter #(.WIDTH(8), .NOT_GATES(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .busy(b_busy)
    );
    serial_not_inverter #(.WIDTH(3), .NOT_GATES(3)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .busy(c_busy)
    );
    serial_not_inverter #(.WIDTH(8), .NOT_GATES(1)) u_d (
        .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .busy(d_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        exp_a = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_out_data", a_out_data, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        chk("rst_d_out_data", d_out_data, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_a_in_ready", a_in_ready, 1);
        chk("rel_b_in_ready", b_in_ready, 1);
        chk("rel_c_in_ready", c_in_ready, 1);
        chk("rel_d_in_ready", d_in_ready, 1);

        // A: exhaustive 3-bit words, one inverter, out_ready high
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            chk("a_in_ready_idle", a_in_ready, 1);
            a_in_valid = 1'b1;
            a_in_data  = 3'(w);
            @(negedge clk);
            a_in_valid = 1'b0;
            chk("a_busy_shift", a_busy, 1);
            chk("a_in_ready_shift", a_in_ready, 0);
            lat = 0;
            while (!a_out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("a_latency", lat, 3);
            chk("a_out_data", a_out_data, exp_a[w]);
        end
        @(negedge clk);
        chk("a_busy_after", a_busy, 0);
        chk("a_out_valid_after", a_out_valid, 0);

        // B: 8-bit, two inverters, back-to-back words; in_data wiggles during SHIFT
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = 8'hA5;
        chk("b_in_ready_idle", b_in_ready, 1);
        @(negedge clk);
        chk("b_busy", b_busy, 1);
        chk("b_in_ready_s1", b_in_ready, 0);
        b_in_data = 8'h33;
        @(negedge clk);
        chk("b_in_ready_s2", b_in_ready, 0);
        b_in_data = 8'hCC;
        @(negedge clk);
        chk("b_out_valid_s3", b_out_valid, 0);
        b_in_data = 8'h0F;
        @(negedge clk);
        chk("b_out_valid_s4", b_out_valid, 0);
        @(negedge clk);
        chk("b_out_valid_w1", b_out_valid, 1);
        chk("b_out_data_w1", b_out_data, 8'h5A);
        chk("b_in_ready_done", b_in_ready, 1);
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("b_out_valid_drop", b_out_valid, 0);
        chk("b_busy_b2b", b_busy, 1);
        repeat (3) begin
            @(negedge clk);
            chk("b_out_valid_w2_early", b_out_valid, 0);
        end
        @(negedge clk);
        chk("b_out_valid_w2", b_out_valid, 1);
        chk("b_out_data_w2", b_out_data, 8'hF0);
        @(negedge clk);
        chk("b_busy_after", b_busy, 0);
        chk("b_in_ready_after", b_in_ready, 1);

        // C: BEATS=1 with six cycles of backpressure; in_valid in DONE is ignored
        @(negedge clk);
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_data   = 3'b110;
        @(negedge clk);
        c_in_valid = 1'b0;
        chk("c_out_valid_shift", c_out_valid, 0);
        @(negedge clk);
        c_in_valid = 1'b1;
        c_in_data  = 3'b011;
        for (int i = 0; i < 6; i++) begin
            chk("c_bp_out_valid", c_out_valid, 1);
            chk("c_bp_out_data", c_out_data, 3'b001);
            chk("c_bp_in_ready", c_in_ready, 0);
            if (i < 5) @(negedge clk);
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        @(negedge clk);
        chk("c_release_out_valid", c_out_valid, 0);
        chk("c_release_busy", c_busy, 0);
        chk("c_release_in_ready", c_in_ready, 1);

        // D: asynchronous reset in beat 2 discards the word in flight
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in_data  = 8'h5C;
        @(negedge clk);
        d_in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("d_busy_pre", d_busy, 1);
        chk("d_partial", d_out_data, 8'hC0);
        #1 reset = 1'b1;
        #1;
        chk("d_rst_out_valid", d_out_valid, 0);
        chk("d_rst_busy", d_busy, 0);
        chk("d_rst_out_data", d_out_data, 0);
        chk("d_rst_in_ready", d_in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("d_rst_hold_in_ready", d_in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("d_rel_in_ready", d_in_ready, 1);
        chk("d_rel_out_valid", d_out_valid, 0);
        d_in_valid = 1'b1;
        d_in_data  = 8'h00;
        @(negedge clk);
        d_in_valid = 1'b0;
        lat = 0;
        while (!d_out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("d_latency", lat, 8);
        chk("d_out_data", d_out_data, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
